// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: shared widths and responder state encoding for the SRAM line path
package gpu_mem_pkg;
    localparam int LINE_W = 1536;
    localparam int WORD_W = 64;
    localparam int ADDR_W = 24;
    localparam int BEATS  = LINE_W / WORD_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int MEM_AW = ADDR_W + BEAT_W;
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} resp_state_t;
endpackage

// File: rtl/sram_line_responder_if.sv
// sram_line_responder_if: line request bus plus narrow SRAM port seen by the responder
interface sram_line_responder_if;
    import gpu_mem_pkg::*;
    logic              read_enable;
    logic              write_enable;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] write_data;
    logic              busy;
    logic              done;
    logic [LINE_W-1:0] read_data;
    logic              mem_re;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    modport slave (
        input  read_enable, write_enable, address, write_data, mem_rdata,
        output busy, done, read_data, mem_re, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output read_enable, write_enable, address, write_data, mem_rdata,
        input  busy, done, read_data, mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_line_responder_beat_counter.sv
// sram_beat_counter: loadable, enable-gated 0..BEATS-1 counter with terminal-count flag
module sram_beat_counter
    import gpu_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BEAT_W-1:0] load_val,
    input  logic              en,
    output logic [BEAT_W-1:0] count,
    output logic              tc
);
    logic [BEAT_W-1:0] count_q, count_d;
    assign count = count_q;
    always_comb begin
        tc = count_q == BEAT_W'(BEATS - 1);
        count_d = load ? load_val : en ? (tc ? '0 : count_q + 1'b1) : count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else count_q <= count_d;
    end
endmodule

// File: rtl/sram_line_responder.sv
// sram_line_responder: serialises one line read/write into WORD_W beats on a
// single-port SRAM and reassembles read beats into read_data
module sram_line_responder
    import gpu_mem_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    sram_line_responder_if.slave bus
);
    resp_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d, asm_q, asm_d, read_data_q, read_data_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BEAT_W-1:0] iss, cap, beat_d;
    logic              iss_tc, cap_tc, idle, iss_en, cap_en;

    sram_beat_counter u_iss (.clk(clk), .rst(rst), .load(idle), .load_val('0), .en(iss_en), .count(iss), .tc(iss_tc));
    sram_beat_counter u_cap (.clk(clk), .rst(rst), .load(idle), .load_val('0), .en(cap_en), .count(cap), .tc(cap_tc));

    always_comb begin
        idle = state_q == IDLE;
        iss_en = state_q == WRITE || state_q == READ;
        // read data arrives one cycle after its strobe, so capture trails issue by one beat
        cap_en = (state_q == READ && iss != '0) || state_q == DRAIN;
        state_d = state_q;
        addr_d = addr_q;
        wline_d = wline_q;
        case (state_q)
            IDLE: if (bus.write_enable || bus.read_enable) begin
                state_d = bus.write_enable ? WRITE : READ;
                addr_d = bus.address;
                wline_d = bus.write_enable ? bus.write_data : wline_q;
            end
            WRITE: state_d = iss_tc ? DONE : WRITE;
            READ: state_d = iss_tc ? DRAIN : READ;
            DRAIN: state_d = DONE;
            default: state_d = IDLE;
        endcase
        asm_d = asm_q;
        if (cap_en) asm_d[cap*WORD_W +: WORD_W] = bus.mem_rdata;
        read_data_d = cap_en && cap_tc ? asm_d : read_data_q;
        beat_d = idle ? '0 : iss + 1'b1;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
        mem_we_d = state_d == WRITE;
        mem_re_d = state_d == READ;
        mem_addr_d = mem_we_d || mem_re_d ? {addr_d, beat_d} : mem_addr_q;
        mem_wdata_d = mem_we_d ? wline_d[beat_d*WORD_W +: WORD_W] : mem_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            wline_q <= '0;
            asm_q <= '0;
            read_data_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            wline_q <= wline_d;
            asm_q <= asm_d;
            read_data_q <= read_data_d;
            busy_q <= busy_d;
            done_q <= done_d;
            mem_re_q <= mem_re_d;
            mem_we_q <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.read_data = read_data_q;
    assign bus.mem_re = mem_re_q;
    assign bus.mem_we = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
